gesture_frame_rx: RTL and testbench

//  UART receiver and frame validator for gesture codes sent by the EMG classifier MCU.

---
 rtl/gesture_frame_rx.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_gesture_frame_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gesture_frame_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gesture_frame_rx
//   UART receiver and frame validator for gesture codes sent by the EMG
//   classifier MCU. Frames are 0xA5, CODE, CSUM (CSUM = 0xA5 ^ CODE), carried
//   on an 8N1 LSB-first serial line. A code is applied only after CONFIRM_CNT
//   consecutive identical valid frames. If no valid frame arrives for
//   TIMEOUT_MS, the gesture is forced to the neutral code 0x00.
//
// Ports
//   clk           in   1  system clock
//   rst_n         in   1  synchronous active-low reset
//   uart_rx       in   1  asynchronous serial input, idles high
//   gesture       out  8  confirmed gesture code (to gesture_decoder)
//   gesture_valid out  1  1-cycle pulse when gesture changes value
//   frame_err     out  1  1-cycle pulse on stop-bit error or checksum mismatch
//   link_timeout  out  1  level, high while the link is silent past TIMEOUT_MS
// -----------------------------------------------------------------------------
module gesture_frame_rx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int CONFIRM_CNT = 2,
  parameter int TIMEOUT_MS  = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] gesture,
  output logic       gesture_valid,
  output logic       frame_err,
  output logic       link_timeout
);

  localparam int BIT_CYC     = CLK_HZ / BAUD;
  localparam int HALF        = BIT_CYC / 2;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int BC_W        = $clog2(BIT_CYC + 1);
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [3:0]      CONFIRM   = 4'(CONFIRM_CNT);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(BIT_CYC - 1);
  localparam logic [BC_W-1:0] HALF_LAST = BC_W'(HALF - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  // Expected checksum byte for a given code.
  function automatic logic [7:0] frame_csum(input logic [7:0] code);
    return SYNC_BYTE ^ code;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer plus one delayed copy for falling-edge detection
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchronizer; rx_prev_q holds the previous synchronized sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART byte receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  uart_state_e     uart_q;
  logic [BC_W-1:0] baud_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            byte_stb_q;
  logic            stop_err_q;

  // Receiver FSM: start-bit qualification at mid-bit, then 8 data bits and
  // the stop bit sampled one bit period apart. STOP returns to IDLE right at
  // the sample point, so a low stop bit never triggers a false start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_q     <= U_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_q     <= 8'h00;
      byte_stb_q <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      byte_stb_q <= 1'b0;
      stop_err_q <= 1'b0;
      case (uart_q)
        U_IDLE: begin
          baud_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) begin
            uart_q <= U_START;
          end else begin
            uart_q <= U_IDLE;
          end
        end
        U_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            // A line back high at mid start bit is a glitch: drop it silently.
            uart_q     <= rx_sync_q ? U_IDLE : U_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + BC_W'(1);
          end
        end
        U_DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_sync_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              uart_q <= U_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BC_W'(1);
          end
        end
        U_STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            uart_q     <= U_IDLE;
            if (rx_sync_q) begin
              byte_q     <= shift_q;
              byte_stb_q <= 1'b1;
            end else begin
              stop_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BC_W'(1);
          end
        end
        default: begin
          uart_q     <= U_IDLE;
          baud_cnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser, confirmation filter and link timeout
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {F_HUNT, F_CODE, F_CSUM} frame_state_e;

  frame_state_e    frm_q, frm_d;
  logic [7:0]      code_q, code_d;
  logic [7:0]      cand_q, cand_d;
  logic [3:0]      match_q, match_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      gesture_q, gesture_d;
  logic            gv_q, gv_d;
  logic            fe_q, fe_d;
  logic            lt_q, lt_d;
  logic            valid_s;
  logic            csum_bad_s;

  // Next-state logic for the frame FSM, candidate/match tracking and timeout.
  always_comb begin
    frm_d      = frm_q;
    code_d     = code_q;
    cand_d     = cand_q;
    match_d    = match_q;
    to_cnt_d   = to_cnt_q;
    gesture_d  = gesture_q;
    gv_d       = 1'b0;
    fe_d       = 1'b0;
    lt_d       = lt_q;
    valid_s    = 1'b0;
    csum_bad_s = 1'b0;

    if (stop_err_q) begin
      fe_d  = 1'b1;
      frm_d = F_HUNT;
    end else if (byte_stb_q) begin
      case (frm_q)
        F_HUNT: begin
          if (byte_q == SYNC_BYTE) begin
            frm_d = F_CODE;
          end else begin
            frm_d = F_HUNT;
          end
        end
        F_CODE: begin
          code_d = byte_q;
          frm_d  = F_CSUM;
        end
        F_CSUM: begin
          frm_d = F_HUNT;
          if (byte_q == frame_csum(code_q)) begin
            valid_s = 1'b1;
          end else begin
            csum_bad_s = 1'b1;
          end
        end
        default: begin
          frm_d = F_HUNT;
        end
      endcase
    end else begin
      frm_d = frm_q;
    end

    if (valid_s) begin
      // A valid frame always restarts the silence timer, even at expiry.
      to_cnt_d = '0;
      lt_d     = 1'b0;
      if (code_q == cand_q) begin
        match_d = (match_q >= CONFIRM) ? CONFIRM : match_q + 4'd1;
      end else begin
        cand_d  = code_q;
        match_d = 4'd1;
      end
      if ((match_d == CONFIRM) && (code_q != gesture_q)) begin
        gesture_d = code_q;
        gv_d      = 1'b1;
      end else begin
        gesture_d = gesture_q;
      end
    end else begin
      if (csum_bad_s) begin
        fe_d    = 1'b1;
        match_d = 4'd0;
      end else begin
        match_d = match_q;
      end
      if (to_cnt_q == TO_LAST) begin
        // Expiry slips by one cycle when an error pulse is going out, so
        // frame_err and gesture_valid never coincide.
        if (fe_d) begin
          to_cnt_d = to_cnt_q;
        end else begin
          to_cnt_d = TO_MAX;
          lt_d     = 1'b1;
          cand_d   = 8'h00;
          match_d  = 4'd0;
          if (gesture_q != 8'h00) begin
            gesture_d = 8'h00;
            gv_d      = 1'b1;
          end else begin
            gesture_d = gesture_q;
          end
        end
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_d = to_cnt_q;
      end
    end
  end

  // State and output registers for the frame/confirmation logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frm_q     <= F_HUNT;
      code_q    <= 8'h00;
      cand_q    <= 8'h00;
      match_q   <= 4'd0;
      to_cnt_q  <= '0;
      gesture_q <= 8'h00;
      gv_q      <= 1'b0;
      fe_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      frm_q     <= frm_d;
      code_q    <= code_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      to_cnt_q  <= to_cnt_d;
      gesture_q <= gesture_d;
      gv_q      <= gv_d;
      fe_q      <= fe_d;
      lt_q      <= lt_d;
    end
  end

  assign gesture       = gesture_q;
  assign gesture_valid = gv_q;
  assign frame_err     = fe_q;
  assign link_timeout  = lt_q;

endmodule

// File: tb/tb_gesture_frame_rx.sv
`timescale 1ns/1ps
// Directed bench for gesture_frame_rx with scaled-down timing:
// 5 MHz nominal clock, 100 kbaud (50 cycles/bit), 2 ms timeout (10000 cycles).
module tb_gesture_frame_rx;

  localparam int BIT_CYC = 50;
  localparam int TO_CYC  = 10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] gesture;
  logic       gesture_valid;
  logic       frame_err;
  logic       link_timeout;

  int vectors = 0;
  int miscompares = 0;
  int gv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  gesture_frame_rx #(
    .CLK_HZ     (5_000_000),
    .BAUD       (100_000),
    .CONFIRM_CNT(2),
    .TIMEOUT_MS (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .gesture      (gesture),
    .gesture_valid(gesture_valid),
    .frame_err    (frame_err),
    .link_timeout (link_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters for the strobe outputs.
  always @(posedge clk) begin
    if (gesture_valid) gv_cnt <= gv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (gesture_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    send_byte(code, 1'b1);
    send_byte(cs, 1'b1);
  endtask

  int g0;
  int f0;
  int waited;

  initial begin
    // 1. Reset and idle line
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gesture", {24'd0, gesture}, 32'h00);
    check("rst_gv", {31'd0, gesture_valid}, 32'd0);
    check("rst_fe", {31'd0, frame_err}, 32'd0);
    check("rst_lt", {31'd0, link_timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_gesture", {24'd0, gesture}, 32'h00);
    check("idle_pulses", gv_cnt + fe_cnt, 0);

    // Reset in the middle of a byte (start bit plus three data bits of 0xA5)
    uart_rx = 1'b0; repeat (BIT_CYC) @(negedge clk);
    uart_rx = 1'b1; repeat (BIT_CYC) @(negedge clk);
    uart_rx = 1'b0; repeat (BIT_CYC) @(negedge clk);
    uart_rx = 1'b1; repeat (BIT_CYC / 2) @(negedge clk);
    uart_rx = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h07, 8'hA2);
    check("t1_first_frame_no_change", {24'd0, gesture}, 32'h00);
    send_frame(8'h07, 8'hA2);
    check("t1_gesture_07", {24'd0, gesture}, 32'h07);
    check("t1_gv_once", gv_cnt, 1);
    check("t1_no_err", fe_cnt, 0);

    // 2. Two frames of 0x03 confirm; a third produces no pulse
    g0 = gv_cnt;
    send_frame(8'h03, 8'hA6);
    check("t2_frame1_hold", {24'd0, gesture}, 32'h07);
    check("t2_frame1_no_pulse", gv_cnt, g0);
    send_frame(8'h03, 8'hA6);
    check("t2_gesture_03", {24'd0, gesture}, 32'h03);
    check("t2_one_pulse", gv_cnt, g0 + 1);
    send_frame(8'h03, 8'hA6);
    check("t2_repeat_no_pulse", gv_cnt, g0 + 1);

    // 3. Switching to 0x04 needs two frames
    send_frame(8'h03, 8'hA6);
    send_frame(8'h04, 8'hA1);
    check("t3_after_one_04", {24'd0, gesture}, 32'h03);
    send_frame(8'h04, 8'hA1);
    check("t3_gesture_04", {24'd0, gesture}, 32'h04);
    check("t3_pulse", gv_cnt, g0 + 2);

    // 4. Bad checksum, then stop-bit error mid-frame returns to HUNT
    f0 = fe_cnt;
    g0 = gv_cnt;
    send_frame(8'h03, 8'h00);
    check("t4_csum_err", fe_cnt, f0 + 1);
    check("t4_csum_gesture", {24'd0, gesture}, 32'h04);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b0);
    check("t4_stop_err", fe_cnt, f0 + 2);
    // In HUNT these two bytes are ignored; only one valid 0x06 frame follows
    send_byte(8'h06, 1'b1);
    send_byte(8'hA3, 1'b1);
    send_frame(8'h06, 8'hA3);
    check("t4_hunt_gesture", {24'd0, gesture}, 32'h04);
    check("t4_hunt_no_pulse", gv_cnt, g0);
    check("t4_hunt_no_err", fe_cnt, f0 + 2);

    // 5. 200 ns glitch, noise bytes, then two 0x05 frames
    f0 = fe_cnt;
    uart_rx = 1'b0;
    #200;
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_glitch_no_err", fe_cnt, f0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_frame(8'h05, 8'hA0);
    check("t5_one_05_hold", {24'd0, gesture}, 32'h04);
    send_frame(8'h05, 8'hA0);
    check("t5_gesture_05", {24'd0, gesture}, 32'h05);
    check("t5_no_err", fe_cnt, f0);

    // 6. Silence until timeout, then a valid frame clears link_timeout
    g0 = gv_cnt;
    repeat (TO_CYC - 1000) @(negedge clk);
    check("t6_before_lt", {31'd0, link_timeout}, 32'd0);
    check("t6_before_gesture", {24'd0, gesture}, 32'h05);
    waited = 0;
    while (!gesture_valid && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("t6_timeout_pulse", {31'd0, gesture_valid}, 32'd1);
    check("t6_gesture_00", {24'd0, gesture}, 32'h00);
    check("t6_lt_high", {31'd0, link_timeout}, 32'd1);
    @(negedge clk);
    check("t6_pulse_single", {31'd0, gesture_valid}, 32'd0);
    check("t6_gv_count", gv_cnt, g0 + 1);
    send_frame(8'h09, 8'hAC);
    check("t6_lt_cleared", {31'd0, link_timeout}, 32'd0);
    check("t6_gesture_still_00", {24'd0, gesture}, 32'h00);

    check("no_fe_gv_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
